bt_pipe_in_buffer: RTL and testbench

Block-throttled pipe-in endpoint on the host-interface endpoint bus. Decodes the ok1 broadcast bus (block strobe, write command, address, data) and returns the READY flag on its ok2 slice. Buffers one or more fixed-size host blocks in an internal FIFO. Presents the words to FPGA-side logic (e.g. the Bluetooth TX path) through a first-word-fall-through read port.

---
 rtl/bt_pipe_in_buffer_pkg.sv | 45 ++++
 rtl/bt_pipe_in_buffer_sync_fifo_fwft.sv | 70 +++++++
 rtl/bt_pipe_in_buffer.sv | 166 ++++++++++++++++
 tb/tb_bt_pipe_in_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bt_pipe_in_buffer_pkg.sv
// Shared host-interface endpoint bus definitions and pipe-in FSM types.
// The ok1/ok2 bit indices match the host model and the other endpoints.
package bt_pipe_in_buffer_pkg;

   localparam int OK1_WIDTH          = 31;
   localparam int OK2_WIDTH          = 17;

   localparam int OK_TI_DATAIN_START = 0;
   localparam int OK_TI_DATAIN_END   = 15;
   localparam int OK_TI_ADDR_START   = 16;
   localparam int OK_TI_ADDR_END     = 23;
   localparam int OK_TI_BLOCKSTROBE  = 24;
   localparam int OK_TI_READ         = 25;
   localparam int OK_TI_WRITE        = 26;
   localparam int OK_TI_WIREUPDATE   = 27;
   localparam int OK_TI_TRIGUPDATE   = 28;
   localparam int OK_TI_RESET        = 29;
   localparam int OK_TI_CLK          = 30;
   localparam int OK_TI_CMD_START    = 24;
   localparam int OK_TI_CMD_END      = 28;

   localparam int OK_DATAOUT_START   = 0;
   localparam int OK_DATAOUT_END     = 15;
   localparam int OK_READY           = 16;

   // One-hot command codes as seen in ok1[OK_TI_CMD_END:OK_TI_CMD_START]
   localparam logic [4:0] OK_CMD_BLOCKSTROBE = 5'b00001;
   localparam logic [4:0] OK_CMD_READ        = 5'b00010;
   localparam logic [4:0] OK_CMD_WRITE       = 5'b00100;
   localparam logic [4:0] OK_CMD_WIREUPDATE  = 5'b01000;
   localparam logic [4:0] OK_CMD_TRIGUPDATE  = 5'b10000;

   localparam logic [7:0] OK_PIPEIN_ADDR_MIN = 8'h80;
   localparam logic [7:0] OK_PIPEIN_ADDR_MAX = 8'h9F;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } pipe_state_e;

   function automatic logic is_pipein_addr(input logic [7:0] addr);
      return (addr >= OK_PIPEIN_ADDR_MIN) && (addr <= OK_PIPEIN_ADDR_MAX);
   endfunction

endpackage

// File: rtl/bt_pipe_in_buffer_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with an explicit occupancy counter.
// A push at full is accepted only when a pop is taken on the same edge.
module sync_fifo_fwft #(
   parameter int WIDTH      = 16,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  push,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  pop,
   output logic [WIDTH-1:0]      rdata,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  push_drop
);

   localparam int                DEPTH_WORDS = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] ZERO_CNT   = {(DEPTH_LOG2+1){1'b0}};

   logic [WIDTH-1:0]      mem_r [DEPTH_WORDS];
   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rd_ptr_r;
   logic [DEPTH_LOG2:0]   level_r;
   logic                  push_ok_s;
   logic                  pop_ok_s;

   // Accept decisions for this edge
   always_comb begin
      pop_ok_s  = pop && (level_r != ZERO_CNT);
      push_ok_s = push && ((level_r != DEPTH_CNT) || pop_ok_s);
   end

   // Storage write port
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointers wrap modulo depth; occupancy tracked separately
   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr_r <= {DEPTH_LOG2{1'b0}};
         rd_ptr_r <= {DEPTH_LOG2{1'b0}};
         level_r  <= ZERO_CNT;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_r <= level_r + 1'b1;
            2'b01:   level_r <= level_r - 1'b1;
            default: level_r <= level_r;
         endcase
      end
   end

   assign rdata     = mem_r[rd_ptr_r];
   assign full      = (level_r == DEPTH_CNT);
   assign empty     = (level_r == ZERO_CNT);
   assign level     = level_r;
   assign push_drop = push && !push_ok_s;

endmodule

// File: rtl/bt_pipe_in_buffer.sv
// Block-throttled pipe-in endpoint: decodes ok1, buffers host blocks in a FIFO,
// and advertises READY on ok2 only while a whole block of space is free.
module bt_pipe_in_buffer
   import bt_pipe_in_buffer_pkg::*;
#(
   parameter logic [7:0] EP_ADDR     = 8'h80,
   parameter int         BLOCK_WORDS = 256,
   parameter int         DEPTH_LOG2  = 10
) (
   input  logic                  ti_clk,
   input  logic                  reset,
   input  logic [OK1_WIDTH-1:0]  ok1,
   output logic [OK2_WIDTH-1:0]  ok2,
   input  logic                  rd_en,
   output logic [15:0]           rd_data,
   output logic                  rd_valid,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  block_done,
   output logic                  overflow,
   output logic                  proto_err
);

   localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] ZERO_CNT   = {(DEPTH_LOG2+1){1'b0}};
   localparam logic [DEPTH_LOG2:0] BLOCK_LEN  = (DEPTH_LOG2+1)'(BLOCK_WORDS);
   localparam logic [DEPTH_LOG2:0] LAST_COUNT = BLOCK_LEN - 1'b1;

   pipe_state_e         state_r;
   pipe_state_e         state_nx_s;
   logic                ready_r;
   logic [DEPTH_LOG2:0] count_r;
   logic                block_done_r;
   logic                proto_err_r;
   logic                overflow_r;

   logic                clear_s;
   logic                hit_s;
   logic                strobe_s;
   logic [DEPTH_LOG2:0] free_s;
   logic [DEPTH_LOG2:0] level_s;
   logic                empty_s;
   logic                full_s;
   logic                drop_s;
   logic                push_s;
   logic                start_s;
   logic                last_s;
   logic                err_s;
   logic                unused_ok1_s;

   assign clear_s  = reset || ok1[OK_TI_RESET];
   assign strobe_s = ok1[OK_TI_BLOCKSTROBE];
   assign hit_s    = ok1[OK_TI_WRITE]
                     && (ok1[OK_TI_ADDR_END:OK_TI_ADDR_START] == EP_ADDR)
                     && is_pipein_addr(EP_ADDR);
   assign free_s   = DEPTH_CNT - level_s;
   // Read, wire-update and trigger-update commands have no effect on a pipe-in
   assign unused_ok1_s = ^{ok1[OK_TI_READ], ok1[OK_TI_WIREUPDATE],
                           ok1[OK_TI_TRIGUPDATE], ok1[OK_TI_CLK], full_s};

   // FSM state register
   always_ff @(posedge ti_clk) begin
      if (clear_s) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (ready_r && strobe_s) begin
               state_nx_s = ST_RECV;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RECV: begin
            if (hit_s && (count_r == LAST_COUNT)) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_RECV;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // FSM decoded actions
   always_comb begin
      push_s  = 1'b0;
      start_s = 1'b0;
      last_s  = 1'b0;
      err_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            start_s = ready_r && strobe_s;
            err_s   = hit_s || (strobe_s && !ready_r);
         end
         ST_RECV: begin
            push_s = hit_s;
            last_s = hit_s && (count_r == LAST_COUNT);
         end
         default: begin
            push_s  = 1'b0;
            start_s = 1'b0;
         end
      endcase
   end

   // READY, word count, completion pulse and sticky error flags
   always_ff @(posedge ti_clk) begin
      if (clear_s) begin
         ready_r      <= 1'b0;
         count_r      <= ZERO_CNT;
         block_done_r <= 1'b0;
         proto_err_r  <= 1'b0;
         overflow_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: ready_r <= start_s ? 1'b0 : (free_s >= BLOCK_LEN);
            ST_RECV: ready_r <= 1'b0;
            default: ready_r <= 1'b0;
         endcase
         if (start_s) begin
            count_r <= ZERO_CNT;
         end else if (push_s) begin
            count_r <= count_r + 1'b1;
         end
         block_done_r <= last_s;
         proto_err_r  <= proto_err_r | err_s;
         overflow_r   <= overflow_r | drop_s;
      end
   end

   sync_fifo_fwft #(
      .WIDTH      (16),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk       (ti_clk),
      .clear     (clear_s),
      .push      (push_s),
      .wdata     (ok1[OK_TI_DATAIN_END:OK_TI_DATAIN_START]),
      .pop       (rd_en),
      .rdata     (rd_data),
      .full      (full_s),
      .empty     (empty_s),
      .level     (level_s),
      .push_drop (drop_s)
   );

   // ok2 slice: data field held at zero, READY from its register
   always_comb begin
      ok2           = {OK2_WIDTH{1'b0}};
      ok2[OK_READY] = ready_r;
   end

   assign rd_valid   = !empty_s;
   assign level      = level_s;
   assign block_done = block_done_r;
   assign overflow   = overflow_r;
   assign proto_err  = proto_err_r;

endmodule

// File: tb/tb_bt_pipe_in_buffer.sv
// Directed self-checking bench for bt_pipe_in_buffer (default parameters).
module tb_bt_pipe_in_buffer;
   import bt_pipe_in_buffer_pkg::*;

   logic        ti_clk;
   logic        reset;
   logic [30:0] ok1;
   logic [16:0] ok2;
   logic        rd_en;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic [10:0] level;
   logic        block_done;
   logic        overflow;
   logic        proto_err;

   int checks = 0;
   int passes = 0;
   int bd_cnt = 0;

   bt_pipe_in_buffer #(.EP_ADDR(8'h80), .BLOCK_WORDS(256), .DEPTH_LOG2(10)) dut (
      .ti_clk(ti_clk), .reset(reset), .ok1(ok1), .ok2(ok2), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
      .block_done(block_done), .overflow(overflow), .proto_err(proto_err)
   );

   initial ti_clk = 1'b0;
   always #5 ti_clk = ~ti_clk;

   function automatic logic [30:0] mk(input logic strobe, input logic wr, input logic rd,
                                      input logic [7:0] addr, input logic [15:0] data);
      logic [30:0] v;
      v = 31'd0;
      v[15:0]  = data;
      v[23:16] = addr;
      v[24]    = strobe;
      v[25]    = rd;
      v[26]    = wr;
      return v;
   endfunction

   // Advance one edge; outputs are then stable for sampling
   task automatic step();
      @(posedge ti_clk);
      #1;
      if (block_done === 1'b1) bd_cnt++;
   endtask

   task automatic do_reset();
      reset = 1'b1; ok1 = 31'd0; rd_en = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      bd_cnt = 0;
   endtask

   task automatic send_block(input logic [15:0] base, input int n, input int gap);
      ok1 = mk(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
      step();
      ok1 = 31'd0;
      repeat (gap) step();
      for (int i = 0; i < n; i++) begin
         ok1 = mk(1'b0, 1'b1, 1'b0, 8'h80, base + 16'(i));
         step();
      end
      ok1 = 31'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1; ok1 = 31'd0; rd_en = 1'b0;
      repeat (3) step();
      checks++; if (ok2 !== 17'h00000) $display("FAIL rst_ok2 got=%h exp=%h", ok2, 17'h00000); else passes++;
      checks++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid got=%b exp=0", rd_valid); else passes++;
      checks++; if (level !== 11'd0) $display("FAIL rst_level got=%0d exp=0", level); else passes++;
      checks++; if ({block_done, overflow, proto_err} !== 3'b000) $display("FAIL rst_flags got=%b exp=000", {block_done, overflow, proto_err}); else passes++;
      reset = 1'b0;
      checks++; if (ok2 !== 17'h00000) $display("FAIL rel_ok2_c1 got=%h exp=%h", ok2, 17'h00000); else passes++;
      step();
      checks++; if (ok2 !== 17'h10000) $display("FAIL rel_ok2_c2 got=%h exp=%h", ok2, 17'h10000); else passes++;
      step();
      checks++; if (ok2 !== 17'h10000) $display("FAIL rel_ok2_c3 got=%h exp=%h", ok2, 17'h10000); else passes++;
   endtask

   task automatic test_single_block();
      int errs;
      do_reset();
      step(); step();
      ok1 = mk(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
      step();
      checks++; if (ok2[16] !== 1'b0) $display("FAIL blk_ready_drop got=%b exp=0", ok2[16]); else passes++;
      ok1 = 31'd0;
      step();
      for (int i = 0; i < 256; i++) begin
         ok1 = mk(1'b0, 1'b1, 1'b0, 8'h80, 16'(i));
         step();
         if (i == 0) begin
            checks++; if (level !== 11'd1 || rd_data !== 16'h0000) $display("FAIL blk_first_word got=%0d/%h exp=1/0000", level, rd_data); else passes++;
         end
      end
      ok1 = 31'd0;
      checks++; if (level !== 11'd256) $display("FAIL blk_level got=%0d exp=256", level); else passes++;
      checks++; if (block_done !== 1'b1) $display("FAIL blk_done_pulse got=%b exp=1", block_done); else passes++;
      checks++; if (ok2[16] !== 1'b0) $display("FAIL blk_ready_at_done got=%b exp=0", ok2[16]); else passes++;
      step();
      checks++; if (block_done !== 1'b0) $display("FAIL blk_done_clear got=%b exp=0", block_done); else passes++;
      checks++; if (ok2[16] !== 1'b1) $display("FAIL blk_ready_back got=%b exp=1", ok2[16]); else passes++;
      errs = 0;
      rd_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         if (rd_valid !== 1'b1 || rd_data !== 16'(i)) errs++;
         step();
      end
      rd_en = 1'b0;
      checks++; if (errs != 0) $display("FAIL blk_pop_order got=%0d bad words exp=0", errs); else passes++;
      checks++; if (level !== 11'd0 || rd_valid !== 1'b0) $display("FAIL blk_drained got=%0d/%b exp=0/0", level, rd_valid); else passes++;
      checks++; if (bd_cnt != 1) $display("FAIL blk_done_count got=%0d exp=1", bd_cnt); else passes++;
   endtask

   task automatic test_addr_filter();
      do_reset();
      step(); step();
      for (int i = 0; i < 4; i++) begin
         ok1 = mk(1'b0, 1'b1, 1'b0, 8'h81, 16'h5500 + 16'(i));
         step();
         ok1 = mk(1'b0, 1'b0, 1'b1, 8'h80, 16'h6600 + 16'(i));
         step();
      end
      ok1 = 31'd0;
      step();
      checks++; if (level !== 11'd0 || rd_valid !== 1'b0) $display("FAIL filt_level got=%0d/%b exp=0/0", level, rd_valid); else passes++;
      checks++; if (proto_err !== 1'b0) $display("FAIL filt_proto_err got=%b exp=0", proto_err); else passes++;
   endtask

   task automatic test_fill_four();
      int errs;
      do_reset();
      step(); step();
      for (int b = 0; b < 4; b++) begin
         send_block(16'(b * 256), 256, 0);
         step();
         checks++; if (ok2[16] !== (b < 3)) $display("FAIL fill_ready_b%0d got=%b exp=%b", b, ok2[16], (b < 3)); else passes++;
      end
      checks++; if (level !== 11'd1024) $display("FAIL fill_level got=%0d exp=1024", level); else passes++;
      checks++; if (overflow !== 1'b0 || proto_err !== 1'b0) $display("FAIL fill_flags got=%b%b exp=00", overflow, proto_err); else passes++;
      checks++; if (bd_cnt != 4) $display("FAIL fill_done_count got=%0d exp=4", bd_cnt); else passes++;
      errs = 0;
      rd_en = 1'b1;
      for (int i = 0; i < 255; i++) begin
         if (rd_data !== 16'(i)) errs++;
         step();
      end
      rd_en = 1'b0;
      step();
      checks++; if (errs != 0) $display("FAIL fill_pop_order got=%0d bad words exp=0", errs); else passes++;
      checks++; if (ok2[16] !== 1'b0 || level !== 11'd769) $display("FAIL fill_255_pops got=%b/%0d exp=0/769", ok2[16], level); else passes++;
      // A strobe while not ready, then a stray write, must both be rejected
      ok1 = mk(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
      step();
      ok1 = mk(1'b0, 1'b1, 1'b0, 8'h80, 16'hDEAD);
      step();
      ok1 = 31'd0;
      checks++; if (proto_err !== 1'b1 || level !== 11'd769) $display("FAIL fill_strobe_not_ready got=%b/%0d exp=1/769", proto_err, level); else passes++;
      checks++; if (rd_data !== 16'h00FF) $display("FAIL fill_head got=%h exp=00ff", rd_data); else passes++;
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      checks++; if (ok2[16] !== 1'b0 || level !== 11'd768) $display("FAIL fill_256th_pop got=%b/%0d exp=0/768", ok2[16], level); else passes++;
      step();
      checks++; if (ok2[16] !== 1'b1) $display("FAIL fill_ready_after_pop got=%b exp=1", ok2[16]); else passes++;
   endtask

   task automatic test_excess_words();
      do_reset();
      step(); step();
      send_block(16'h1000, 257, 0);
      checks++; if (level !== 11'd256) $display("FAIL excess_level got=%0d exp=256", level); else passes++;
      checks++; if (proto_err !== 1'b1 || overflow !== 1'b0) $display("FAIL excess_flags got=%b%b exp=10", proto_err, overflow); else passes++;
      checks++; if (rd_data !== 16'h1000) $display("FAIL excess_head got=%h exp=1000", rd_data); else passes++;
   endtask

   task automatic test_no_strobe();
      do_reset();
      step(); step();
      ok1 = mk(1'b0, 1'b1, 1'b0, 8'h80, 16'hBEEF);
      step();
      ok1 = 31'd0;
      step();
      checks++; if (proto_err !== 1'b1 || level !== 11'd0) $display("FAIL nostrobe got=%b/%0d exp=1/0", proto_err, level); else passes++;
   endtask

   task automatic test_clear_mid_block();
      do_reset();
      step(); step();
      send_block(16'h3000, 100, 1);
      checks++; if (level !== 11'd100) $display("FAIL clr_partial got=%0d exp=100", level); else passes++;
      ok1 = 31'd0;
      ok1[29] = 1'b1;
      step();
      ok1 = 31'd0;
      checks++; if (level !== 11'd0 || rd_valid !== 1'b0 || ok2 !== 17'h00000) $display("FAIL clr_state got=%0d/%b/%h exp=0/0/00000", level, rd_valid, ok2); else passes++;
      step();
      checks++; if (ok2[16] !== 1'b1) $display("FAIL clr_ready got=%b exp=1", ok2[16]); else passes++;
      checks++; if (bd_cnt != 0) $display("FAIL clr_no_done got=%0d exp=0", bd_cnt); else passes++;
      send_block(16'h2000, 256, 2);
      step();
      checks++; if (level !== 11'd256 || rd_data !== 16'h2000) $display("FAIL clr_new_block got=%0d/%h exp=256/2000", level, rd_data); else passes++;
      checks++; if (bd_cnt != 1 || proto_err !== 1'b0) $display("FAIL clr_new_done got=%0d/%b exp=1/0", bd_cnt, proto_err); else passes++;
   endtask

   initial begin
      reset = 1'b1; ok1 = 31'd0; rd_en = 1'b0;
      test_reset();
      test_single_block();
      test_addr_filter();
      test_fill_four();
      test_excess_words();
      test_no_strobe();
      test_clear_mid_block();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
